// File: rtl/sorting_pkg.sv
// -----------------------------------------------------------------------------
// sorting_pkg
//   Shared types for the packet sorter. Holds the control-state enumeration
//   used by the top level. Word width and packet capacity stay as module
//   parameters of sorting, so nothing here depends on them.
// -----------------------------------------------------------------------------
package sorting_pkg;

    // IDLE : waiting for a word with sop_i
    // LOAD : collecting words until eop_i
    // SORT : N odd-even transposition passes over the storage
    // OUT  : streaming the first L sorted words
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SORT = 2'd2,
        OUT  = 2'd3
    } state_t;

endpackage : sorting_pkg

// File: rtl/sorting_cmp_swap.sv
// -----------------------------------------------------------------------------
// sorting_cmp_swap
//   Combinational compare-and-swap cell for the sorting network. The smaller
//   of the two unsigned inputs appears on lo, the larger on hi. Equal inputs
//   pass straight through, so duplicates are preserved.
//
// Ports
//   a, b   : unsigned input words
//   lo, hi : min(a, b) and max(a, b)
// -----------------------------------------------------------------------------
module sorting_cmp_swap
    import sorting_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    output logic [DWIDTH-1:0] lo,
    output logic [DWIDTH-1:0] hi
);

    logic swap;

    assign swap = (a > b);
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule : sorting_cmp_swap

// File: rtl/sorting.sv
// -----------------------------------------------------------------------------
// sorting
//   Packet sorter. Collects a packet of up to N = 2**AWIDTH words framed by
//   sop_i / eop_i, sorts it ascending (unsigned) with an odd-even
//   transposition network running one pass per cycle for N cycles, then
//   streams the first L words back out framed by sop_o / eop_o. While
//   sorting or emitting, busy_o is high and the input is ignored.
//
// Parameters
//   DWIDTH : data word width in bits
//   AWIDTH : log2 of the packet capacity N
//
// Ports
//   clk_i   : clock, rising edge
//   srst_i  : asynchronous active-high reset (aborts any packet in flight)
//   data_i  : input word
//   sop_i   : first word of input packet
//   eop_i   : last word of input packet
//   val_i   : input word valid
//   data_o  : sorted output word (holds its last value outside OUT)
//   sop_o   : first word of output packet
//   eop_o   : last word of output packet
//   val_o   : output word valid
//   busy_o  : high while sorting or emitting
// -----------------------------------------------------------------------------
module sorting
    import sorting_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 3
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              sop_i,
    input  logic              eop_i,
    input  logic              val_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              sop_o,
    output logic              eop_o,
    output logic              val_o,
    output logic              busy_o
);

    localparam int                N         = 2 ** AWIDTH;
    // Length and output index must reach N itself, hence one extra bit.
    localparam int                LW        = AWIDTH + 1;
    localparam logic [LW-1:0]     N_LEN     = LW'(N);
    localparam logic [AWIDTH-1:0] LAST_PASS = '1;

    state_t                   state;
    logic [LW-1:0]            len;
    logic [LW-1:0]            len_nxt;
    logic [LW-1:0]            out_idx;
    logic [AWIDTH-1:0]        pass_cnt;
    logic [AWIDTH-1:0]        ld_idx;
    logic                     ld_we;
    logic                     go_sort;

    logic [N-1:0][DWIDTH-1:0] mem;
    logic [N-1:0][DWIDTH-1:0] even_q;
    logic [N-1:0][DWIDTH-1:0] odd_q;

    // -------------------------------------------------------------------------
    // Load decode: where the current input word goes, the resulting packet
    // length, and whether this word closes the packet.
    // -------------------------------------------------------------------------
    always_comb begin
        ld_we   = 1'b0;
        ld_idx  = '0;
        len_nxt = len;
        go_sort = 1'b0;
        case (state)
            IDLE: begin
                if (val_i && sop_i) begin
                    ld_we   = 1'b1;
                    ld_idx  = '0;
                    len_nxt = LW'(1);
                    go_sort = eop_i;
                end
            end
            LOAD: begin
                if (val_i) begin
                    if (sop_i) begin
                        // A fresh sop throws away the partial packet.
                        ld_we   = 1'b1;
                        ld_idx  = '0;
                        len_nxt = LW'(1);
                    end else if (len < N_LEN) begin
                        ld_we   = 1'b1;
                        ld_idx  = len[AWIDTH-1:0];
                        len_nxt = len + LW'(1);
                    end
                    // Words past capacity are dropped, but their eop still
                    // closes the packet.
                    go_sort = eop_i;
                end
            end
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Sorting network: even pass compares (0,1),(2,3),...; odd pass compares
    // (1,2),(3,4),... with the two end entries passing through.
    // -------------------------------------------------------------------------
    for (genvar p = 0; p < N / 2; p++) begin : g_even
        sorting_cmp_swap #(
            .DWIDTH (DWIDTH)
        ) u_cmp_swap (
            .a  (mem[2*p]),
            .b  (mem[2*p+1]),
            .lo (even_q[2*p]),
            .hi (even_q[2*p+1])
        );
    end

    for (genvar p = 0; p < N / 2 - 1; p++) begin : g_odd
        sorting_cmp_swap #(
            .DWIDTH (DWIDTH)
        ) u_cmp_swap (
            .a  (mem[2*p+1]),
            .b  (mem[2*p+2]),
            .lo (odd_q[2*p+1]),
            .hi (odd_q[2*p+2])
        );
    end

    assign odd_q[0]   = mem[0];
    assign odd_q[N-1] = mem[N-1];

    // -------------------------------------------------------------------------
    // Storage: written during load, rewritten by one network pass per SORT
    // cycle. Contents are never reset; unused slots are padded with all-ones
    // as the packet closes so they sink to the top and are never emitted.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (state == SORT) begin
            mem <= pass_cnt[0] ? odd_q : even_q;
        end else begin
            if (ld_we) begin
                mem[ld_idx] <= data_i;
            end
            if (go_sort) begin
                for (int i = 0; i < N; i++) begin
                    if (LW'(i) >= len_nxt) begin
                        mem[i] <= '1;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs. SORT runs exactly N passes; the
    // first word is registered out on the edge after the last pass, giving
    // N+1 cycles from the eop edge to the first val_o.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state    <= IDLE;
            len      <= '0;
            pass_cnt <= '0;
            out_idx  <= '0;
            data_o   <= '0;
            val_o    <= 1'b0;
            sop_o    <= 1'b0;
            eop_o    <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    len <= len_nxt;
                    if (go_sort) begin
                        state    <= SORT;
                        busy_o   <= 1'b1;
                        pass_cnt <= '0;
                    end else if (ld_we) begin
                        state <= LOAD;
                    end
                end
                SORT: begin
                    pass_cnt <= pass_cnt + AWIDTH'(1);
                    if (pass_cnt == LAST_PASS) begin
                        state   <= OUT;
                        out_idx <= '0;
                    end
                end
                OUT: begin
                    if (out_idx < len) begin
                        data_o  <= mem[out_idx[AWIDTH-1:0]];
                        val_o   <= 1'b1;
                        sop_o   <= (out_idx == '0);
                        eop_o   <= (out_idx == len - LW'(1));
                        out_idx <= out_idx + LW'(1);
                    end else begin
                        // Last word went out on the previous edge.
                        state  <= IDLE;
                        val_o  <= 1'b0;
                        sop_o  <= 1'b0;
                        eop_o  <= 1'b0;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : sorting

// File: tb/tb_sorting.sv
// -----------------------------------------------------------------------------
// tb_sorting
//   Self-checking bench for the packet sorter. A queue-based model decides
//   which words each input packet keeps and sorts them; one monitor compares
//   every output cycle against that model, including busy_o and the
//   eop-to-first-word latency.
// -----------------------------------------------------------------------------
module tb_sorting;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int N  = 2 ** AW;

    logic          clk_i = 1'b0;
    logic          srst_i;
    logic [DW-1:0] data_i;
    logic          sop_i;
    logic          eop_i;
    logic          val_i;
    logic [DW-1:0] data_o;
    logic          sop_o;
    logic          eop_o;
    logic          val_o;
    logic          busy_o;

    always #5 clk_i = ~clk_i;

    sorting #(
        .DWIDTH (DW),
        .AWIDTH (AW)
    ) dut (
        .clk_i  (clk_i),
        .srst_i (srst_i),
        .data_i (data_i),
        .sop_i  (sop_i),
        .eop_i  (eop_i),
        .val_i  (val_i),
        .data_o (data_o),
        .sop_o  (sop_o),
        .eop_o  (eop_o),
        .val_o  (val_o),
        .busy_o (busy_o)
    );

    int     checks   = 0;
    int     failures = 0;

    // Expected output stream, one entry per output word.
    int     exp_d[$];
    bit     exp_s[$];
    bit     exp_e[$];
    bit     exp_busy  = 1'b0;
    bit     pend_idle = 1'b0;
    bit     mon_en    = 1'b0;
    longint eop_time  = 0;

    // Beat table for the driver.
    int     nb;
    int     bd[16];
    bit     bs[16];
    bit     be[16];
    bit     bv[16];

    int     pv[$];
    int     lv[$];
    int     mq[$];
    int     m_eop;

    int     mon_d;
    bit     mon_s;
    bit     mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Model: walk the beats, keep words of the current packet (restart on
    // sop, drop beyond N, close on eop), then sort ascending.
    task automatic model();
        int pkt[$];
        bit act = 1'b0;
        mq.delete();
        m_eop = -1;
        for (int i = 0; i < nb; i++) begin
            if (bv[i]) begin
                if (bs[i]) begin
                    pkt.delete();
                    pkt.push_back(bd[i]);
                    act = 1'b1;
                end else if (act && pkt.size() < N) begin
                    pkt.push_back(bd[i]);
                end
                if (act && be[i]) begin
                    m_eop = i;
                    break;
                end
            end
        end
        pkt.sort();
        if (m_eop >= 0) mq = pkt;
    endtask

    task automatic build();
        nb = pv.size();
        for (int i = 0; i < nb; i++) begin
            bd[i] = pv[i];
            bv[i] = 1'b1;
            bs[i] = (i == 0);
            be[i] = (i == nb - 1);
        end
    endtask

    task automatic push_expected();
        for (int i = 0; i < mq.size(); i++) begin
            exp_d.push_back(mq[i]);
            exp_s.push_back(i == 0);
            exp_e.push_back(i == mq.size() - 1);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < nb; i++) begin
            data_i = DW'(bd[i]);
            sop_i  = bs[i];
            eop_i  = be[i];
            val_i  = bv[i];
            @(posedge clk_i);
            if (i == m_eop) begin
                eop_time = $time;
                exp_busy = 1'b1;
            end
            #1;
        end
        val_i = 1'b0;
        sop_i = 1'b0;
        eop_i = 1'b0;
    endtask

    task automatic junk();
        for (int j = 0; j < 3; j++) begin
            data_i = DW'(100 + j);
            sop_i  = 1'b1;
            eop_i  = 1'b1;
            val_i  = 1'b1;
            @(posedge clk_i);
            #1;
        end
        val_i = 1'b0;
        sop_i = 1'b0;
        eop_i = 1'b0;
    endtask

    task automatic run(input string name, input bit use_lit, input bit with_junk);
        int t = 0;
        model();
        if (use_lit) begin
            chk({name, "_model_len"}, mq.size(), lv.size());
            for (int i = 0; i < lv.size(); i++)
                chk({name, "_model_word"}, (i < mq.size()) ? mq[i] : -1, lv[i]);
        end
        push_expected();
        drive();
        if (with_junk) junk();
        while (t < 200 && (exp_d.size() != 0 || exp_busy)) begin
            @(posedge clk_i);
            t++;
        end
        #1;
        chk({name, "_done"}, (exp_d.size() == 0 && !exp_busy), 1);
    endtask

    // Monitor: compare every cycle against the model stream.
    always @(negedge clk_i) begin
        if (mon_en && !srst_i) begin
            if (pend_idle) begin
                pend_idle = 1'b0;
                exp_busy  = 1'b0;
                chk("idle_val", val_o, 0);
                chk("idle_sop", sop_o, 0);
                chk("idle_eop", eop_o, 0);
            end else if (val_o) begin
                if (exp_d.size() == 0) begin
                    chk("spurious_val", val_o, 0);
                end else begin
                    mon_d = exp_d.pop_front();
                    mon_s = exp_s.pop_front();
                    mon_e = exp_e.pop_front();
                    chk("data", data_o, mon_d);
                    chk("sop", sop_o, mon_s);
                    chk("eop", eop_o, mon_e);
                    if (mon_s) chk("latency", ($time - eop_time - 5) / 10, N + 1);
                    if (mon_e) pend_idle = 1'b1;
                end
            end else begin
                chk("sop_without_val", sop_o, 0);
                chk("eop_without_val", eop_o, 0);
            end
            chk("busy", busy_o, exp_busy);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        srst_i = 1'b1;
        data_i = '0;
        sop_i  = 1'b0;
        eop_i  = 1'b0;
        val_i  = 1'b0;
        @(posedge clk_i);
        #1;
        chk("rst_data", data_o, 0);
        chk("rst_val", val_o, 0);
        chk("rst_sop", sop_o, 0);
        chk("rst_eop", eop_o, 0);
        chk("rst_busy", busy_o, 0);
        @(posedge clk_i);
        #1;
        srst_i = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;

        pv = '{5, 3, 7, 1};
        lv = '{1, 3, 5, 7};
        build();
        run("pkt4", 1'b1, 1'b1);

        pv = '{255, 0, 17, 17, 200, 3, 255, 9};
        lv = '{0, 3, 9, 17, 17, 200, 255, 255};
        build();
        run("full8", 1'b1, 1'b0);

        pv = '{42};
        lv = '{42};
        build();
        run("single", 1'b1, 1'b0);

        pv = '{50, 40, 30, 20, 10, 60, 70, 80, 5, 1};
        lv = '{10, 20, 30, 40, 50, 60, 70, 80};
        build();
        run("trunc10", 1'b1, 1'b1);

        // Stray word without sop while idle, then a restart mid-packet.
        pv = '{77, 9, 8, 4, 6};
        lv = '{4, 6};
        build();
        bs[0] = 1'b0;
        bs[1] = 1'b1;
        bs[3] = 1'b1;
        run("restart", 1'b1, 1'b0);

        // Reset in the middle of OUT.
        pv = '{30, 10, 40, 20};
        build();
        model();
        push_expected();
        drive();
        repeat (10) @(posedge clk_i);
        #3;
        srst_i = 1'b1;
        exp_d.delete();
        exp_s.delete();
        exp_e.delete();
        exp_busy  = 1'b0;
        pend_idle = 1'b0;
        #1;
        chk("abort_data", data_o, 0);
        chk("abort_val", val_o, 0);
        chk("abort_sop", sop_o, 0);
        chk("abort_eop", eop_o, 0);
        chk("abort_busy", busy_o, 0);
        repeat (2) @(posedge clk_i);
        #1;
        srst_i = 1'b0;

        pv = '{2, 1};
        lv = '{1, 2};
        build();
        run("after_reset", 1'b1, 1'b0);

        for (int r = 0; r < 3; r++) begin
            int n;
            n = int'($urandom_range(3, 7));
            pv.delete();
            for (int i = 0; i < n; i++) pv.push_back(int'($urandom_range(0, 255)));
            build();
            run("random", 1'b0, 1'b0);
        end

        repeat (3) @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sorting
